// File: rtl/noc_inject_arbiter_if.sv
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

`default_nettype none

// ============================================================================
// Module   : noc_inject_arbiter_if
// Purpose  : Local requester bundle plus the single NoC injection port.
//            'master' is the arbiter view; 'slave' is the requester/NoC view.
// Revision : 1.0 - initial release
// ============================================================================
interface noc_inject_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = `Noc_Data_Width
);
    // Local requester side
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_flit;
    logic [N_REQ-1:0]        req_is_header;
    logic [N_REQ-1:0]        req_is_tail;

    // NoC injection side
    logic                    sender_valid;
    logic                    sender_ready;
    logic [DATA_W-1:0]       sender_flit;
    logic                    sender_is_header;
    logic                    sender_is_tail;

    modport master (
        input  req_valid,
        output req_ready,
        input  req_flit,
        input  req_is_header,
        input  req_is_tail,
        output sender_valid,
        input  sender_ready,
        output sender_flit,
        output sender_is_header,
        output sender_is_tail
    );

    modport slave (
        output req_valid,
        input  req_ready,
        output req_flit,
        output req_is_header,
        output req_is_tail,
        input  sender_valid,
        output sender_ready,
        input  sender_flit,
        input  sender_is_header,
        input  sender_is_tail
    );
endinterface

`default_nettype wire

// File: rtl/noc_inject_arbiter.sv
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

`default_nettype none

// ============================================================================
// Module   : noc_inject_arbiter
// Purpose  : Packet-locked round-robin arbiter merging N_REQ local flit
//            streams onto one NoC injection port, with packet counter and
//            sticky per-requester protocol-error flags.
// Revision : 1.0 - initial release
// ============================================================================
module noc_inject_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = `Noc_Data_Width
) (
    input  wire logic                     noc_clk,
    input  wire logic                     noc_rst_n,
    noc_inject_arbiter_if.master          bus,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy,
    output logic [15:0]                   pkt_count,
    output logic [N_REQ-1:0]              proto_err
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [ID_W-1:0]   r_grant_id,  w_grant_nxt;
    logic [ID_W-1:0]   r_rr_ptr,    w_rr_nxt;
    logic [15:0]       r_pkt_count, w_pkt_nxt;
    logic [N_REQ-1:0]  r_proto_err, w_perr_nxt;
    // Set while the next transfer of the locked packet is its first flit;
    // a header seen on any later transfer is a protocol error.
    logic              r_first,     w_first_nxt;

    logic [N_REQ-1:0]  w_cand;
    logic              w_found;
    logic [ID_W-1:0]   w_pick;
    logic              w_xfer;
    int                w_idx;

    assign grant_id  = r_grant_id;
    assign busy      = (r_state == ST_LOCKED);
    assign pkt_count = r_pkt_count;
    assign proto_err = r_proto_err;

    // Next-state, arbitration and injection-port muxing
    always_comb begin
        w_state_nxt          = r_state;
        w_grant_nxt          = r_grant_id;
        w_rr_nxt             = r_rr_ptr;
        w_pkt_nxt            = r_pkt_count;
        w_perr_nxt           = r_proto_err;
        w_first_nxt          = r_first;
        w_cand               = bus.req_valid & bus.req_is_header;
        w_found              = 1'b0;
        w_pick               = '0;
        w_xfer               = 1'b0;
        w_idx                = 0;
        bus.req_ready        = '0;
        bus.sender_valid     = 1'b0;
        bus.sender_flit      = '0;
        bus.sender_is_header = 1'b0;
        bus.sender_is_tail   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Non-header flits offered while nobody owns the port are illegal
                w_perr_nxt = r_proto_err | (bus.req_valid & ~bus.req_is_header);
                // Search upward from rr_ptr with wrap; first header wins
                for (int i = 0; i < N_REQ; i++) begin
                    w_idx = int'(r_rr_ptr) + i;
                    if (w_idx >= N_REQ) begin
                        w_idx = w_idx - N_REQ;
                    end
                    if (!w_found && w_cand[w_idx]) begin
                        w_found = 1'b1;
                        w_pick  = w_idx[ID_W-1:0];
                    end
                end
                if (w_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = w_pick;
                    w_first_nxt = 1'b1;
                end
            end

            ST_LOCKED: begin
                bus.sender_valid             = bus.req_valid[r_grant_id];
                bus.sender_flit              = bus.req_flit[int'(r_grant_id)*DATA_W +: DATA_W];
                bus.sender_is_header         = bus.req_is_header[r_grant_id];
                bus.sender_is_tail           = bus.req_is_tail[r_grant_id];
                bus.req_ready[r_grant_id]    = bus.sender_ready;
                w_xfer = bus.sender_valid && bus.sender_ready;
                if (w_xfer) begin
                    w_first_nxt = 1'b0;
                    if (!r_first && bus.sender_is_header) begin
                        w_perr_nxt[r_grant_id] = 1'b1;
                    end
                    if (bus.sender_is_tail) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_rr_nxt    = (r_grant_id == ID_W'(N_REQ-1)) ? '0
                                                                     : r_grant_id + ID_W'(1);
                        w_pkt_nxt   = r_pkt_count + 16'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and bookkeeping registers with synchronous active-low reset
    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_pkt_count <= '0;
            r_proto_err <= '0;
            r_first     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_id  <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_pkt_count <= w_pkt_nxt;
            r_proto_err <= w_perr_nxt;
            r_first     <= w_first_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_noc_inject_arbiter.sv
`default_nettype none

// ============================================================================
// Module   : tb_noc_inject_arbiter
// Purpose  : Directed, table-driven bench for noc_inject_arbiter (N_REQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_inject_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic        noc_clk   = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] pkt_count;
    logic [3:0]  proto_err;

    noc_inject_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus_if ();

    noc_inject_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .bus       (bus_if),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_count (pkt_count),
        .proto_err (proto_err)
    );

    always #5 noc_clk = ~noc_clk;

    typedef struct {
        bit          rst_n;
        logic [3:0]  valid;
        logic [3:0]  hdr;
        logic [3:0]  tail;
        bit          sr;
        bit          e_sv;
        logic [3:0]  e_rdy;
        bit          e_h;
        bit          e_t;
        logic [1:0]  e_gid;
        bit          e_busy;
        logic [15:0] e_cnt;
        logic [3:0]  e_perr;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pos[4];
    logic [3:0] lh, lt;
    int   k, ph, g;

    // Distinct flit per requester and per cycle so a wrong mux or a stale flit shows up
    function automatic logic [31:0] mkflit(int id, int seq);
        return {8'(id + 1), 8'h5A, 16'(seq)};
    endfunction

    task automatic row(bit r, logic [3:0] v, logic [3:0] h, logic [3:0] t, bit sr,
                       bit esv, logic [3:0] erdy, bit eh, bit et, logic [1:0] gid,
                       bit eb, logic [15:0] cnt, logic [3:0] perr);
        vec_t x;
        x.rst_n = r;   x.valid = v;  x.hdr = h;   x.tail = t;  x.sr = sr;
        x.e_sv  = esv; x.e_rdy = erdy; x.e_h = eh; x.e_t = et; x.e_gid = gid;
        x.e_busy = eb; x.e_cnt = cnt; x.e_perr = perr;
        vecs.push_back(x);
    endtask

    task automatic drive(bit r, logic [3:0] v, logic [3:0] h, logic [3:0] t, bit sr, int seq);
        noc_rst_n            = r;
        bus_if.req_valid     = v;
        bus_if.req_is_header = h;
        bus_if.req_is_tail   = t;
        bus_if.sender_ready  = sr;
        for (int i = 0; i < N; i++) begin
            bus_if.req_flit[i*DW +: DW] = mkflit(i, seq);
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string tag, bit esv, logic [3:0] erdy, bit eh, bit et,
                                 logic [1:0] gid, bit eb, logic [15:0] cnt,
                                 logic [3:0] perr, int seq);
        logic [31:0] eflit;
        eflit = eb ? mkflit(int'(gid), seq) : 32'h0;
        check({tag, ".sender_valid"}, 32'(bus_if.sender_valid),     32'(esv));
        check({tag, ".req_ready"},    32'(bus_if.req_ready),        32'(erdy));
        check({tag, ".sender_flit"},  bus_if.sender_flit,           eflit);
        check({tag, ".is_header"},    32'(bus_if.sender_is_header), 32'(eh));
        check({tag, ".is_tail"},      32'(bus_if.sender_is_tail),   32'(et));
        check({tag, ".grant_id"},     32'(grant_id),                32'(gid));
        check({tag, ".busy"},         32'(busy),                    32'(eb));
        check({tag, ".pkt_count"},    32'(pkt_count),               32'(cnt));
        check({tag, ".proto_err"},    32'(proto_err),               32'(perr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: a non-header offer must not set proto_err
        row(0, 4'b0100, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd0, 4'b0000);
        // Req 0 and req 2 each send 3 flits; req 0 first, one IDLE cycle, then req 2
        row(1, 4'b0101, 4'b0101, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd0, 4'b0000);
        row(1, 4'b0101, 4'b0101, 4'b0000, 1, 1, 4'b0001, 1, 0, 2'd0, 1, 16'd0, 4'b0000);
        row(1, 4'b0101, 4'b0100, 4'b0000, 1, 1, 4'b0001, 0, 0, 2'd0, 1, 16'd0, 4'b0000);
        row(1, 4'b0101, 4'b0100, 4'b0001, 1, 1, 4'b0001, 0, 1, 2'd0, 1, 16'd0, 4'b0000);
        row(1, 4'b0100, 4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd1, 4'b0000);
        row(1, 4'b0100, 4'b0100, 4'b0000, 1, 1, 4'b0100, 1, 0, 2'd2, 1, 16'd1, 4'b0000);
        row(1, 4'b0100, 4'b0000, 4'b0000, 1, 1, 4'b0100, 0, 0, 2'd2, 1, 16'd1, 4'b0000);
        row(1, 4'b0100, 4'b0000, 4'b0100, 1, 1, 4'b0100, 0, 1, 2'd2, 1, 16'd1, 4'b0000);
        row(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd2, 4'b0000);
        // rr_ptr is now 3: req 3 beats req 0; single-flit packet from req 3
        row(1, 4'b1001, 4'b1001, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd2, 4'b0000);
        row(1, 4'b1001, 4'b1001, 4'b1000, 1, 1, 4'b1000, 1, 1, 2'd3, 1, 16'd2, 4'b0000);
        // Req 1 packet under a stalling sender while req 3 waits
        row(1, 4'b1010, 4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd3, 4'b0000);
        row(1, 4'b1010, 4'b1010, 4'b0000, 1, 1, 4'b0010, 1, 0, 2'd1, 1, 16'd3, 4'b0000);
        row(1, 4'b1010, 4'b1000, 4'b0000, 0, 1, 4'b0000, 0, 0, 2'd1, 1, 16'd3, 4'b0000);
        row(1, 4'b1000, 4'b1000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd1, 1, 16'd3, 4'b0000);
        row(1, 4'b1010, 4'b1000, 4'b0000, 1, 1, 4'b0010, 0, 0, 2'd1, 1, 16'd3, 4'b0000);
        row(1, 4'b1010, 4'b1000, 4'b0010, 0, 1, 4'b0000, 0, 1, 2'd1, 1, 16'd3, 4'b0000);
        row(1, 4'b1010, 4'b1000, 4'b0010, 1, 1, 4'b0010, 0, 1, 2'd1, 1, 16'd3, 4'b0000);
        row(1, 4'b1000, 4'b1000, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd4, 4'b0000);
        row(1, 4'b1000, 4'b1000, 4'b1000, 1, 1, 4'b1000, 1, 1, 2'd3, 1, 16'd4, 4'b0000);
        // Req 2 non-header in IDLE: sticky flag, survives a later good packet
        row(1, 4'b0100, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd5, 4'b0000);
        row(1, 4'b0100, 4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd5, 4'b0100);
        row(1, 4'b0100, 4'b0100, 4'b0100, 1, 1, 4'b0100, 1, 1, 2'd2, 1, 16'd5, 4'b0100);
        row(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd6, 4'b0100);
        // Req 0 repeats a header on its second flit: flagged but still forwarded
        row(1, 4'b0001, 4'b0001, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd6, 4'b0100);
        row(1, 4'b0001, 4'b0001, 4'b0000, 1, 1, 4'b0001, 1, 0, 2'd0, 1, 16'd6, 4'b0100);
        row(1, 4'b0001, 4'b0001, 4'b0000, 1, 1, 4'b0001, 1, 0, 2'd0, 1, 16'd6, 4'b0100);
        row(1, 4'b0001, 4'b0000, 4'b0001, 1, 1, 4'b0001, 0, 1, 2'd0, 1, 16'd6, 4'b0101);
        row(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd7, 4'b0101);
        // Reset after the 2nd flit of a req 1 packet, then a fresh req 1 packet
        row(1, 4'b0010, 4'b0010, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd7, 4'b0101);
        row(1, 4'b0010, 4'b0010, 4'b0000, 1, 1, 4'b0010, 1, 0, 2'd1, 1, 16'd7, 4'b0101);
        row(1, 4'b0010, 4'b0000, 4'b0000, 1, 1, 4'b0010, 0, 0, 2'd1, 1, 16'd7, 4'b0101);
        row(0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 4'b0010, 0, 0, 2'd1, 1, 16'd7, 4'b0101);
        row(1, 4'b0010, 4'b0010, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd0, 4'b0000);
        row(1, 4'b0010, 4'b0010, 4'b0010, 1, 1, 4'b0010, 1, 1, 2'd1, 1, 16'd0, 4'b0000);
        row(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd0, 0, 16'd1, 4'b0000);

        // Initial reset
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        repeat (2) @(posedge noc_clk);

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge noc_clk);
            drive(vecs[v].rst_n, vecs[v].valid, vecs[v].hdr, vecs[v].tail, vecs[v].sr, v + 1);
            #1;
            check_outputs($sformatf("vec%0d", v), vecs[v].e_sv, vecs[v].e_rdy, vecs[v].e_h,
                          vecs[v].e_t, vecs[v].e_gid, vecs[v].e_busy, vecs[v].e_cnt,
                          vecs[v].e_perr, v + 1);
        end

        // All four requesters continuously offer 3-flit packets after a reset:
        // grant order 0,1,2,3,0 with 1 IDLE cycle + 3 transfers per packet
        @(negedge noc_clk);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        for (int i = 0; i < 4; i++) pos[i] = 0;
        for (int c = 0; c < 20; c++) begin
            k  = c / 4;
            ph = c % 4;
            g  = k % 4;
            @(negedge noc_clk);
            for (int i = 0; i < 4; i++) begin
                lh[i] = (pos[i] == 0);
                lt[i] = (pos[i] == 2);
            end
            drive(1, 4'b1111, lh, lt, 1, 100 + c);
            #1;
            check_outputs($sformatf("rr%0d", c), ph != 0, (ph != 0) ? 4'(1 << g) : 4'b0000,
                          ph == 1, ph == 3, (ph != 0) ? 2'(g) : 2'd0, ph != 0,
                          16'(k), 4'b0000, 100 + c);
            if (ph != 0) pos[g] = (pos[g] + 1) % 3;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/noc_inject_arbiter.md
NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

Interface
REQ-001 SHALL have parameters N_REQ, default 4, number of local requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default `Noc_Data_Width, flit width.
REQ-003 SHALL have port noc_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port noc_rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester flit valid.
REQ-006 SHALL have port req_ready, output, N_REQ, per-requester flit accepted.
REQ-007 SHALL have port req_flit, input, N_REQ*DATA_W, flits; requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have ports req_is_header and req_is_tail, input, N_REQ each, per-requester flit markers.
REQ-009 SHALL have ports sender_valid (output, 1), sender_ready (input, 1), sender_flit (output, DATA_W), sender_is_header (output, 1) and sender_is_tail (output, 1), forming the single NoC injection port.
REQ-010 SHALL have port grant_id, output, $clog2(N_REQ), index of the locked requester; 0 when IDLE.
REQ-011 SHALL have port busy, output, 1, high in LOCKED.
REQ-012 SHALL have port pkt_count, output, 16, completed packets; wraps 0xFFFF->0.
REQ-013 SHALL have port proto_err, output, N_REQ, sticky per-requester protocol-error flags.

Function
REQ-014 SHALL implement two states: IDLE and LOCKED; a transfer is a cycle with sender_valid && sender_ready.
REQ-015 In IDLE: req_ready all 0 and sender_valid 0; candidates = requesters with req_valid && req_is_header.
REQ-016 In IDLE with at least one candidate: SHALL choose round-robin, searching from rr_ptr upward with wrap; register grant_id and enter LOCKED next cycle (1-cycle arbitration latency, no flit passes in the arbitration cycle).
REQ-017 In LOCKED: sender_valid/flit/is_header/is_tail SHALL be combinational copies of requester grant_id; req_ready[grant_id] = sender_ready; all other req_ready bits 0.
REQ-018 In LOCKED: a transfer with req_is_tail set SHALL return to IDLE next cycle, set rr_ptr = (grant_id+1) mod N_REQ, and increment pkt_count.
REQ-019 A single-flit packet (header and tail on one flit) SHALL complete per REQ-018 on its one transfer.
REQ-020 The packet lock SHALL hold across any number of valid-low or ready-low cycles; there is no timeout and no preemption.
REQ-021 In IDLE: any requester with req_valid=1 and req_is_header=0 SHALL set its proto_err bit; it is not a candidate and is not acknowledged.
REQ-022 In LOCKED: a transfer with req_is_header=1 on any flit after the first SHALL set proto_err[grant_id]; the flit is still forwarded.
REQ-023 proto_err bits SHALL clear only on reset.
REQ-024 rr_ptr SHALL move only on packet completion; a requester losing arbitration keeps its priority position.
REQ-025 Simultaneous tail transfer and new headers: new arbitration starts in the IDLE cycle after completion, using the updated rr_ptr.

Reset
REQ-026 While noc_rst_n=0 at a clock edge: state=IDLE, rr_ptr=0, grant_id=0, busy=0, pkt_count=0, proto_err=0.
REQ-027 While in IDLE, including the reset cycle: req_ready=0 and sender_valid=0, with sender_flit, sender_is_header and sender_is_tail driven 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet with no tail emitted; the first post-reset grant follows REQ-016 with rr_ptr=0.

Verification
REQ-029 Scenario: N_REQ=4; requesters 0 and 2 each hold a 3-flit packet, sender_ready=1 -> req 0 granted first (3 flits), then 1 IDLE cycle, then req 2; pkt_count=2; rr_ptr=3.
REQ-030 Scenario: all four requesters continuously offer 3-flit packets -> grant order 0,1,2,3,0; each packet has 3 transfers followed by 1 IDLE cycle.
REQ-031 Scenario: sender_ready toggles 1,0,0,1,... during a packet from req 1, with req 3 requesting -> no flit from req 3 until req 1's tail transfers; no flit is duplicated or lost.
REQ-032 Scenario: req 2 presents a non-header flit in IDLE -> proto_err=4'b0100, req_ready[2]=0, and the flag stays set after req 2 later sends a valid packet.
REQ-033 Scenario: single-flit packet from req 3 -> one transfer with sender_is_header=1 and sender_is_tail=1; busy=1 for exactly the cycles until that transfer; pkt_count+1.
REQ-034 Scenario: reset asserted after the 2nd flit of a packet from req 1 -> next edge: busy=0, pkt_count=0, sender_valid=0; a new header from req 1 is granted after reset.
